// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_ADDR_W : default instruction-memory word-address width
//   IMEM_DEPTH  : maximum number of words a load session may carry
//   ld_state_e  : loader FSM state encoding
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DEPTH  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader. Receives a 16-bit big-endian word
// count N, then N big-endian 32-bit words, then an XOR checksum byte of all
// data bytes. Words are written to instruction memory as they complete; the
// downstream core is held in reset until a load finishes with a good checksum.
//
// Ports
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-low reset
//   start     : begin a load session (honoured in IDLE, DONE, ERR)
//   in_valid  : upstream byte valid
//   in_data   : upstream byte
//   in_ready  : byte accepted this cycle when in_valid is also high
//   im_we     : instruction-memory write strobe (one cycle per word)
//   im_addr   : instruction-memory word address
//   im_wdata  : instruction word
//   cpu_rst   : active-high core reset, low only in DONE
//   done      : load completed with good checksum
//   err       : load aborted (oversize length or bad checksum)
//   word_cnt  : words written in the current session
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start after reset
// LEN_HI  | expecting N[15:8]
// LEN_LO  | expecting N[7:0], then length is range-checked
// DATA    | packing bytes into words and writing them
// CSUM    | expecting checksum byte
// DONE    | image loaded, core released from reset
// ERR     | session aborted, core held in reset
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int IM_DEPTH = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [31:0] DEPTH_U = 32'(IM_DEPTH);

  ld_state_e          state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         csum_q, csum_d;
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               done_q, err_q, cpu_rst_q;

  logic               xfer;
  logic [15:0]        len_full;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign xfer     = in_valid && in_ready;
  // length as it will be once the current LEN_LO byte is latched
  assign len_full = {len_q[15:8], in_data};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    lane_d  = lane_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_HI;
          len_d   = '0;
          csum_d  = '0;
          lane_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          if (32'(len_full) > DEPTH_U) state_d = ST_ERR;
          else if (len_full == 16'd0)  state_d = ST_CSUM;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d  = csum_q ^ in_data;
          lane_d  = lane_q + 2'd1;
          shreg_d = {shreg_q[15:0], in_data};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {shreg_q, in_data};
            cnt_d   = cnt_inc;
            if (32'(cnt_inc) == 32'(len_q)) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      csum_q    <= '0;
      lane_q    <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      lane_q    <= lane_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      // status flops follow the next state so they change on the same edge
      done_q    <= (state_d == ST_DONE);
      err_q     <= (state_d == ST_ERR);
      cpu_rst_q <= (state_d != ST_DONE);
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_rst  = cpu_rst_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [10:0] word_cnt;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;

  logic [41:0] exp_q[$];
  logic [31:0] img[0:3];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err), .word_cnt(word_cnt)
  );

  // write monitor: every strobe must match the next expected (addr, data)
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      logic [41:0] e;
      nwrites++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_write addr=%0d data=%h expected no write", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({im_addr, im_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr, im_wdata, e[41:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // header, nw words from img[], checksum (xored with flip to corrupt it)
  task automatic load_image(input logic [15:0] n, input int nw,
                            input logic [7:0] flip, input int gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({10'(w), img[w]});
      for (int i = 0; i < 4; i++) begin
        b = img[w][31-8*i -: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
    send_byte(cs ^ flip, gap);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err, word_cnt} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
      errors++;
      $display("FAIL reset_state rdy=%b we=%b a=%0d d=%h crst=%b dn=%b er=%b wc=%0d",
               in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err, word_cnt);
    end
    start = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b expected 0", in_ready);
    end
  endtask

  task automatic test_single_word();
    img[0] = 32'h20080005;
    start_session();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready got %b expected 1", in_ready);
    end
    load_image(16'd1, 1, 8'h00, 0);
    checks++;
    if ({done, err, cpu_rst, word_cnt} !== {1'b1, 1'b0, 1'b0, 11'd1}) begin
      errors++;
      $display("FAIL single_done dn=%b er=%b crst=%b wc=%0d expected 1 0 0 1",
               done, err, cpu_rst, word_cnt);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_ready got %b expected 0", in_ready);
    end
  endtask

  task automatic test_toggle_valid();
    img[0] = 32'h20080005;
    img[1] = 32'h21090003;
    start_session();
    checks++;
    if ({done, cpu_rst} !== 2'b01) begin
      errors++;
      $display("FAIL restart_flags dn=%b crst=%b expected 0 1", done, cpu_rst);
    end
    load_image(16'd2, 2, 8'h00, 1);
    checks++;
    if ({done, err, cpu_rst, word_cnt} !== {1'b1, 1'b0, 1'b0, 11'd2}) begin
      errors++;
      $display("FAIL toggle_done dn=%b er=%b crst=%b wc=%0d expected 1 0 0 2",
               done, err, cpu_rst, word_cnt);
    end
  endtask

  task automatic test_empty();
    start_session();
    load_image(16'd0, 0, 8'h00, 0);
    checks++;
    if ({done, err, cpu_rst, word_cnt} !== {1'b1, 1'b0, 1'b0, 11'd0}) begin
      errors++;
      $display("FAIL empty_good dn=%b er=%b crst=%b wc=%0d expected 1 0 0 0",
               done, err, cpu_rst, word_cnt);
    end
    start_session();
    load_image(16'd0, 0, 8'h01, 0);
    checks++;
    if ({done, err, cpu_rst} !== 3'b011) begin
      errors++;
      $display("FAIL empty_bad_csum dn=%b er=%b crst=%b expected 0 1 1", done, err, cpu_rst);
    end
  endtask

  task automatic test_oversize();
    start_session();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    checks++;
    if ({err, done, cpu_rst, in_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL oversize_err er=%b dn=%b crst=%b rdy=%b expected 1 0 1 0",
               err, done, cpu_rst, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL oversize_hold rdy=%b er=%b expected 0 1", in_ready, err);
      end
    end
    in_valid = 1'b0;
    start_session();
    checks++;
    if ({in_ready, err} !== 2'b10) begin
      errors++;
      $display("FAIL oversize_restart rdy=%b er=%b expected 1 0", in_ready, err);
    end
    // start is ignored mid-session; the header continues from LEN_HI
    img[0] = 32'h0badf00d;
    start_session();
    load_image(16'd1, 1, 8'h00, 0);
    checks++;
    if ({done, word_cnt} !== {1'b1, 11'd1}) begin
      errors++;
      $display("FAIL midsession_start dn=%b wc=%0d expected 1 1", done, word_cnt);
    end
  endtask

  task automatic test_reset_in_data();
    start_session();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_rst, in_ready, im_we, word_cnt, done} !== {1'b1, 1'b0, 1'b0, 11'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset crst=%b rdy=%b we=%b wc=%0d dn=%b expected 1 0 0 0 0",
               cpu_rst, in_ready, im_we, word_cnt, done);
    end
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    img[0] = 32'h00000000;
    start_session();
    load_image(16'd1, 1, 8'h00, 0);
    checks++;
    if ({done, cpu_rst, word_cnt} !== {1'b1, 1'b0, 11'd1}) begin
      errors++;
      $display("FAIL fresh_session dn=%b crst=%b wc=%0d expected 1 0 1", done, cpu_rst, word_cnt);
    end
  endtask

  task automatic test_restart_from_done();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({cpu_rst, done, word_cnt, in_ready} !== {1'b1, 1'b0, 11'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_done crst=%b dn=%b wc=%0d rdy=%b expected 1 0 0 1",
               cpu_rst, done, word_cnt, in_ready);
    end
    img[0] = 32'hCAFEBABE;
    img[1] = 32'h12345678;
    load_image(16'd2, 2, 8'h00, 0);
    checks++;
    if ({done, cpu_rst, word_cnt} !== {1'b1, 1'b0, 11'd2}) begin
      errors++;
      $display("FAIL restart_image dn=%b crst=%b wc=%0d expected 1 0 2", done, cpu_rst, word_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_empty();
    test_oversize();
    test_reset_in_data();
    test_restart_from_done();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || nwrites != 7) begin
      errors++;
      $display("FAIL write_total got %0d writes (%0d pending) expected 7 (0 pending)",
               nwrites, exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
